// File: rtl/dmem_responder.sv
// Memory-side responder for the data-cache m_* strobe/ready bus: one request at a time,
// served from an internal word-addressed RAM after WAIT_CYCLES busy cycles.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for m_strobe; request fields latched on acceptance
// S_BUSY | counting wait states; access performed when cnt reaches 0
// S_ACK  | m_ready (and m_err if misaligned) high; strobe ignored
module dmem_responder #(
  parameter int A_WIDTH     = 32,
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] m_a,
  input  logic [31:0]        m_din,
  output logic [31:0]        m_dout,
  input  logic               m_strobe,
  input  logic [3:0]         m_wen,
  input  logic [1:0]         m_size,
  input  logic               m_rw,
  output logic               m_ready,
  output logic               m_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2+1:0]   a_lat_q;
  logic [31:0]             din_lat_q;
  logic [3:0]              wen_lat_q;
  logic [1:0]              size_lat_q;
  logic                    rw_lat_q;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [31:0]             dout_q;
  logic                    accept;
  logic                    access;
  logic                    misaligned;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    unused_a_hi;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Upper address bits only alias; they never reach the RAM.
  assign unused_a_hi = ^m_a[A_WIDTH-1:DEPTH_LOG2+2];

  assign idx = a_lat_q[DEPTH_LOG2+1:2];
  // Size 11 falls into the word case through size[1].
  assign misaligned = size_lat_q[1] ? (a_lat_q[1:0] != 2'b00)
                                    : (size_lat_q[0] & a_lat_q[0]);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (m_strobe) begin
          state_d = S_BUSY;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept  = (state_q == S_IDLE) && m_strobe;
    access  = (state_q == S_BUSY) && (cnt_q == 4'd0);
    ready_d = access;
    err_d   = access && misaligned;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      a_lat_q    <= '0;
      din_lat_q  <= '0;
      wen_lat_q  <= '0;
      size_lat_q <= '0;
      rw_lat_q   <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      ready_q <= ready_d;
      err_q   <= err_d;
      if (accept) begin
        a_lat_q    <= m_a[DEPTH_LOG2+1:0];
        din_lat_q  <= m_din;
        wen_lat_q  <= m_wen;
        size_lat_q <= m_size;
        rw_lat_q   <= m_rw;
      end
      if (access && !rw_lat_q) dout_q <= mem[idx];
    end
  end

  // RAM is deliberately not reset; state_q gating keeps a reset mid-request from committing.
  always_ff @(posedge clk) begin
    if (access && rw_lat_q && !misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (wen_lat_q[i]) mem[idx][8*i +: 8] <= din_lat_q[8*i +: 8];
      end
    end
  end

  assign m_dout  = dout_q;
  assign m_ready = ready_q;
  assign m_err   = err_q;

endmodule
